// File: rtl/wb_seq_pkg.sv
// Shared types and constants for the sequential Wishbone initiator.
// The state encoding is shared with the bench so traces read the same on both sides.
package wb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_BUS   = 3'd2,
        ST_RHOLD = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    localparam logic [3:0]  SEL_ALL   = 4'hF;
    localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/wb_seq_if.sv
// Wishbone classic link between the sequential initiator and the user-project slave.
// Signal names keep the wbm_*_o / wbm_*_i naming of the management-side bus.
interface wb_seq_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_seq_timer.sv
// Per-beat ack watchdog: counts strobe cycles and flags the TIMEOUT-th one.
// expired is combinational so the FSM can drop the strobe on that same edge.
module wb_seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier strobe cycles, so LAST marks the final allowed one
    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/wb_seq_master.sv
// Sequential multi-word Wishbone classic initiator with valid/ready data streams
// and a per-beat ack timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_WDATA | wr_ready high, waiting for the next write word
// ST_BUS   | cyc/stb high, waiting for ack or timeout
// ST_RHOLD | rd_valid high, waiting for rd_ready
// ST_FIN   | done (and err on abort) pulse, back to idle
module wb_seq_master
    import wb_seq_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done,
    output logic             err,
    wb_seq_if.master         wbm
);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             stb_q, stb_d;
    logic [3:0]       sel_q, sel_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timer_clear;
    logic             timer_expired;

    // stb_q mirrors "state is ST_BUS", so an ack outside a cycle never reaches the FSM
    assign timer_clear = !stb_q || wbm.wbm_ack_i;

    wb_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (stb_q),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rem_d     = rem_q;
        rd_data_d = rd_data_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d  = cmd_we;
                    adr_d = {cmd_addr[31:2], 2'b00};
                    rem_d = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = ST_FIN;
                    end else if (cmd_we) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_WDATA: begin
                if (wr_valid) begin
                    dat_d   = wr_data;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // ack wins over a timeout landing on the same edge
                if (wbm.wbm_ack_i) begin
                    rem_d = rem_q - 1'b1;
                    adr_d = adr_q + ADDR_STEP;
                    if (!we_q) begin
                        rd_data_d = wbm.wbm_dat_i;
                        state_d   = ST_RHOLD;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_RHOLD: begin
                if (rd_ready) begin
                    state_d = (rem_q == '0) ? ST_FIN : ST_BUS;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stb_d      = (state_d == ST_BUS);
        sel_d      = stb_d ? SEL_ALL : 4'h0;
        rd_valid_d = (state_d == ST_RHOLD);
        done_d     = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            stb_q      <= 1'b0;
            sel_q      <= 4'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            stb_q      <= stb_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_WDATA);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

    assign wbm.wbm_cyc_o = stb_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master: command vector table plus reset/late-ack sequence,
// against a memory-backed Wishbone slave with programmable ack latency.
module tb_wb_seq_master;

    localparam int LEN_W = 8;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_we = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [31:0]      wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             rd_ready = 1'b0;
    logic             cmd_ready, wr_ready, rd_valid, done, err;
    logic [31:0]      rd_data;

    wb_seq_if wbm ();

    wb_seq_master #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .err       (err),
        .wbm       (wbm.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave model and bus monitor, both evaluated on the falling edge
    logic [31:0] mem [0:255];
    int          lat = 0;
    bit          ack_en = 1'b1;
    bit          ack_force = 1'b0;
    int          wcnt = 0;
    logic        stb_prev = 1'b0;
    logic [7:0]  idx;
    int          beats = 0, stb_cycles = 0, done_cnt = 0, err_cnt = 0;
    int          err_alone = 0, gap_err = 0, bus_bad = 0;
    logic [31:0] adr_log [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (wbm.wbm_stb_o && !stb_prev) begin
                beats++;
                adr_log.push_back(wbm.wbm_adr_o);
            end
            if (wbm.wbm_stb_o) stb_cycles++;
            if (stb_prev && wbm.wbm_ack_i && wbm.wbm_stb_o) gap_err++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (err && !done) err_alone++;
            if (wbm.wbm_cyc_o !== wbm.wbm_stb_o ||
                wbm.wbm_sel_o !== (wbm.wbm_stb_o ? 4'hF : 4'h0)) bus_bad++;
        end
        stb_prev = wbm.wbm_stb_o;
        if (wbm.wbm_stb_o === 1'b1 && ack_en) begin
            if (wcnt >= lat) begin
                idx = wbm.wbm_adr_o[9:2];
                wbm.wbm_ack_i = 1'b1;
                wbm.wbm_dat_i = mem[idx];
                if (wbm.wbm_we_o) mem[idx] = wbm.wbm_dat_o;
                wcnt = 0;
            end else begin
                wbm.wbm_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            wbm.wbm_ack_i = ack_force;
            wcnt = 0;
        end
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          len;
        int          lat;
        bit          ack_en;
        int          hold;
        logic [31:0] dbase;
        logic [31:0] adr0;
        int          beats;
        int          stb_cyc;
        bit          err;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int n, input vec_t v);
        int          b0, s0, d0, e0, ea0, g0, bb0, a0;
        int          wi, ri, hc, cyc, exp_rd;
        bit          in_word, hold_bad, got_done;
        logic [31:0] cur;
        b0 = beats; s0 = stb_cycles; d0 = done_cnt; e0 = err_cnt;
        ea0 = err_alone; g0 = gap_err; bb0 = bus_bad; a0 = adr_log.size();
        lat = v.lat;
        ack_en = v.ack_en;
        @(negedge clk);
        cmd_we = v.we; cmd_addr = v.addr; cmd_len = LEN_W'(v.len); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wi = 0; ri = 0; hc = 0; in_word = 0; hold_bad = 0; got_done = 0; cur = '0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            wr_valid = v.we && (wi < v.len);
            wr_data  = v.dbase + 32'(wi);
            if (wr_ready && wr_valid) wi++;
            if (rd_valid) begin
                if (!in_word) begin
                    in_word = 1'b1;
                    hc = 0;
                    cur = rd_data;
                    check($sformatf("v%0d rd_data[%0d]", n, ri), rd_data, v.dbase + 32'(ri));
                end else if (rd_data !== cur || wbm.wbm_stb_o !== 1'b0) begin
                    hold_bad = 1'b1;
                end
                rd_ready = (hc >= v.hold);
                if (rd_ready) begin
                    in_word = 1'b0;
                    ri++;
                end
                hc++;
            end else begin
                if (in_word) hold_bad = 1'b1;
                rd_ready = 1'b0;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check($sformatf("v%0d done seen", n), 32'(got_done), 32'd1);
        if (v.len == 0) check($sformatf("v%0d cycles accept->done", n), 32'(cyc), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d cmd_ready after done", n), 32'(cmd_ready), 32'd1);
        @(negedge clk);
        exp_rd = (!v.we && !v.err) ? v.len : 0;
        check($sformatf("v%0d done pulses", n), 32'(done_cnt - d0), 32'd1);
        check($sformatf("v%0d err pulses", n), 32'(err_cnt - e0), 32'(v.err));
        check($sformatf("v%0d err without done", n), 32'(err_alone - ea0), 32'd0);
        check($sformatf("v%0d beats", n), 32'(beats - b0), 32'(v.beats));
        check($sformatf("v%0d stb cycles", n), 32'(stb_cycles - s0), 32'(v.stb_cyc));
        check($sformatf("v%0d stb without gap", n), 32'(gap_err - g0), 32'd0);
        check($sformatf("v%0d cyc/sel consistency", n), 32'(bus_bad - bb0), 32'd0);
        check($sformatf("v%0d read words", n), 32'(ri), 32'(exp_rd));
        check($sformatf("v%0d rd hold stability", n), 32'(hold_bad), 32'd0);
        for (int j = 0; j < beats - b0 && a0 + j < adr_log.size(); j++) begin
            check($sformatf("v%0d adr[%0d]", n, j), adr_log[a0 + j], v.adr0 + 32'(4 * j));
        end
    endtask

    initial begin
        //          we  addr           len lat en hold dbase   adr0           beats stb err
        vecs[0] = '{1'b1, 32'h0000_0100, 4, 0, 1'b1, 0, 32'hA0, 32'h0000_0100, 4, 4,  1'b0};
        vecs[1] = '{1'b0, 32'h0000_0100, 4, 5, 1'b1, 3, 32'hA0, 32'h0000_0100, 4, 24, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0300, 0, 0, 1'b1, 0, 32'h00, 32'h0000_0000, 0, 0,  1'b0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 2, 1, 1'b1, 0, 32'hB0, 32'hFFFF_FFFC, 2, 4,  1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 2, 2, 1'b1, 1, 32'hB0, 32'hFFFF_FFFC, 2, 6,  1'b0};
        vecs[5] = '{1'b1, 32'h0000_0103, 1, 0, 1'b1, 0, 32'hC0, 32'h0000_0100, 1, 1,  1'b0};
        vecs[6] = '{1'b0, 32'h0000_0102, 1, 3, 1'b1, 0, 32'hC0, 32'h0000_0100, 1, 4,  1'b0};
        vecs[7] = '{1'b0, 32'h0000_0200, 3, 0, 1'b0, 0, 32'h00, 32'h0000_0200, 1, 16, 1'b1};
        vecs[8] = '{1'b1, 32'h0000_0204, 2, 0, 1'b0, 0, 32'hD0, 32'h0000_0204, 1, 16, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset wr_ready", 32'(wr_ready), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset cyc", 32'(wbm.wbm_cyc_o), 32'd0);
        check("reset stb", 32'(wbm.wbm_stb_o), 32'd0);
        check("reset we", 32'(wbm.wbm_we_o), 32'd0);
        check("reset sel", 32'(wbm.wbm_sel_o), 32'd0);
        check("reset adr", wbm.wbm_adr_o, 32'd0);
        check("reset dat_o", wbm.wbm_dat_o, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // reset in the middle of a read beat, then a stray ack while idle
        lat = 5;
        ack_en = 1'b1;
        @(negedge clk);
        cmd_we = 1'b0; cmd_addr = 32'h100; cmd_len = LEN_W'(4); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid-read stb high", 32'(wbm.wbm_stb_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-rst cyc", 32'(wbm.wbm_cyc_o), 32'd0);
        check("post-rst rd_valid", 32'(rd_valid), 32'd0);
        check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("post-rst done", 32'(done), 32'd0);
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        check("late ack cyc", 32'(wbm.wbm_cyc_o), 32'd0);
        check("late ack rd_valid", 32'(rd_valid), 32'd0);
        check("late ack cmd_ready", 32'(cmd_ready), 32'd1);
        check("late ack adr", wbm.wbm_adr_o, 32'd0);
        @(negedge clk);
        run_vec(9, vecs[4]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_seq_master.md
# wb_seq_master

Wishbone classic-cycle initiator that executes sequential multi-word read or write commands against the user-project Wishbone slave, which fronts the SDRAM controller. It sits on the management side of the Wishbone link, so benches and on-chip engines can move blocks of words without hand-driving cycles. It accepts one command at a time, issues one single-beat cycle per word with incrementing byte addresses, and streams data through valid/ready ports. It also enforces a per-beat ack timeout.

## Interface
Parameters:
- LEN_W, 8, width of word-count field (max LEN_W'1s words per command)
- TIMEOUT, 255, max cycles stb may stay high without ack (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  start byte address (bits [1:0] ignored, forced 0)
- cmd_len  in  LEN_W  word count
- wr_data  in  32  write word
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted (WDATA state, combinational)
- rd_data  out  32  read word
- rd_valid  out  1  read word valid, held until rd_ready
- rd_ready  in  1  downstream accepts read word
- done  out  1  one-cycle pulse, command finished
- err  out  1  one-cycle pulse with done when aborted by timeout
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle/strobe (always equal)
- wbm_we_o  out  1  latched cmd_we
- wbm_sel_o  out  4  4'hF during a cycle, 0 otherwise
- wbm_adr_o  out  32  current byte address
- wbm_dat_o  out  32  current write word
- wbm_dat_i  in  32  slave read data
- wbm_ack_i  in  1  slave ack

## Operation
- States: IDLE, WDATA, BUS, RHOLD, FIN.
- IDLE: cmd_ready=1. On cmd_valid: latch we, addr&~3, remaining=cmd_len. If cmd_len==0 → FIN. Else write → WDATA, read → BUS.
- WDATA: wr_ready=1. On wr_valid: capture wr_data into wbm_dat_o → BUS.
- BUS: cyc=stb=1, timer increments each cycle. On ack: remaining−1, adr+4 (mod 2^32), timer cleared, cyc/stb low next cycle. Read: capture wbm_dat_i to rd_data → RHOLD. Write: remaining 0 → FIN, else → WDATA.
- RHOLD: rd_valid=1. On rd_ready: remaining 0 → FIN, else → BUS.
- Timeout: timer reaching TIMEOUT with no ack → cyc/stb low, err=1 → FIN. Remaining beats discarded; rd_valid never raised for the aborted beat.
- FIN: done=1 for one cycle → IDLE.
- Ack seen while stb low is ignored. Ack and timeout in the same cycle count as ack (no err).
- All outputs are registered except wr_ready and cmd_ready.

## Timing
- Reset values: cmd_ready=1 (IDLE), wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0, cyc/stb/we=0, sel=0, adr=0, dat_o=0, timer=0.
- rst is sampled on any edge, including mid-cycle. It returns to IDLE next cycle and the bus cycle is abandoned (cyc low).
- Read: accept at edge N → stb high N+1. Ack at edge M → stb low and rd_valid high M+1.
- Write: wr handshake at edge N → stb high N+1.
- stb is low for ≥1 cycle between consecutive beats. This is required by the slave's read-request latch.
- Per-beat overhead: read = 1 gap cycle, plus RHOLD for ≥1 cycle. Write = 1 gap cycle in WDATA, plus the wr handshake.
- done rises 1 cycle after the last completion edge (final ack for writes, final rd handshake for reads).
- Back-to-back commands: cmd_ready reasserts the cycle after done.

## Structure
- Package wb_seq_pkg: state enum, SEL_ALL=4'hF, ADDR_STEP=32'd4.
- Single FSM module. The ack-timeout counter is a natural sub-module, wb_seq_timer (inputs: clear, run; output: expired at TIMEOUT).

## Test plan
- Write 4 words 0xA0..0xA3 at 0x100 with a zero-wait slave: wbm_adr_o shows 0x100, 0x104, 0x108, 0x10C, with stb low ≥1 cycle between beats. Single done, no err.
- Read 4 words from 0x100, slave ack latency 5 cycles: rd_data shows 0xA0..0xA3 in order. Holding rd_ready low for 3 cycles keeps rd_valid/rd_data stable and stb low.
- cmd_len=0: done one cycle after accept; cyc never asserts.
- Slave never acks, TIMEOUT=16: stb high exactly 16 cycles, then drops. done and err pulse together; cmd_ready high next cycle.
- Start address 0xFFFFFFFC, len 2: second beat address 0x00000000. Input address 0x103 is issued as 0x100.
- rst asserted while stb high mid-read: next cycle cyc=0, rd_valid=0, cmd_ready=1. A late ack is ignored; a new command then runs normally.
